// File: rtl/iir_folded_if.sv
// Stream bundle for the folded IIR: sample input channel and result output channel.
interface iir_folded_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/iir_folded.sv
// Folded IIR y[n] = a*x[n] + b*x[n-1] + c*y[n-1] + d*y[n-2], one shared multiplier,
// one term per cycle, modulo 2^W arithmetic throughout.
module iir_folded #(
  parameter int W    = 8,
  parameter int FOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  input  logic          flush,
  iir_folded_if.slave   bus
);

  localparam int SW = $clog2(FOLD);
  localparam logic [SW-1:0] LAST_STEP = SW'(FOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  x_1_q, x_1_d;
  logic [W-1:0]  y_1_q, y_1_d;
  logic [W-1:0]  y_2_q, y_2_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [W-1:0]  coef_sel;
  logic [W-1:0]  oper_sel;
  logic [W-1:0]  product;
  logic [W-1:0]  acc_sum;

  // The step counter picks which coefficient/history pair feeds the shared multiplier.
  always_comb begin
    coef_sel = d_q;
    oper_sel = y_2_q;
    case (step_q)
      2'd0: begin
        coef_sel = a_q;
        oper_sel = x_q;
      end
      2'd1: begin
        coef_sel = b_q;
        oper_sel = x_1_q;
      end
      2'd2: begin
        coef_sel = c_q;
        oper_sel = y_1_q;
      end
      default: begin
        coef_sel = d_q;
        oper_sel = y_2_q;
      end
    endcase
    product = coef_sel * oper_sel;
    acc_sum = acc_q + product;
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    x_d         = x_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    x_1_d       = x_1_q;
    y_1_d       = y_1_q;
    y_2_d       = y_2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        // Flush wins over a same-cycle accept, so that sample starts from zero history.
        if (flush) begin
          x_1_d = '0;
          y_1_d = '0;
          y_2_d = '0;
        end
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.in_data;
          a_d        = a;
          b_d        = b;
          c_d        = c;
          d_d        = d;
          acc_d      = '0;
          step_d     = '0;
          in_ready_d = 1'b0;
          state_d    = MAC;
        end
      end

      MAC: begin
        acc_d  = acc_sum;
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          step_d      = '0;
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end

      OUT: begin
        // History only advances once the sink has taken the result.
        if (bus.out_ready) begin
          x_1_d       = x_q;
          y_2_d       = y_1_q;
          y_1_d       = out_data_q;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        step_d      = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      x_1_q       <= '0;
      y_1_q       <= '0;
      y_2_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      x_1_q       <= x_1_d;
      y_1_q       <= y_1_d;
      y_2_q       <= y_2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_iir_folded.sv
// Randomized bench for iir_folded against a plain-arithmetic difference-equation model.
module tb_iir_folded;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, c, d;
  logic         flush;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mx1, my1, my2;
  logic [W-1:0] got;

  iir_folded_if #(.W(W)) bus_if ();

  iir_folded #(.W(W), .FOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .flush (flush),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] refModel(input logic [W-1:0] x, input logic [W-1:0] ca,
                                            input logic [W-1:0] cb, input logic [W-1:0] cc,
                                            input logic [W-1:0] cd);
    int s;
    s = int'(ca) * int'(x) + int'(cb) * int'(mx1) + int'(cc) * int'(my1) + int'(cd) * int'(my2);
    return W'(s % 256);
  endfunction

  task automatic clearModel();
    mx1 = '0;
    my1 = '0;
    my2 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(bus_if.out_valid), 0);
    checkOutput("rst_out_data", 32'(bus_if.out_data), 0);
    repeat (2) @(negedge clk);
    rst_n            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    flush            = 1'b0;
    clearModel();
    #1;
    checkOutput("rst_in_ready", 32'(bus_if.in_ready), 1);
  endtask

  task automatic applyFlush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clearModel();
    checkOutput("flush_in_ready", 32'(bus_if.in_ready), 1);
  endtask

  // One full sample: accept, wait for the result, optionally stall the sink, then hand it off.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] ca, input logic [W-1:0] cb,
                               input logic [W-1:0] cc, input logic [W-1:0] cd, input bit fl,
                               input int hold, input bit chg, output logic [W-1:0] y);
    logic [W-1:0] exp_y;
    int lat;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(bus_if.in_ready), 1);
    a = ca; b = cb; c = cc; d = cd;
    flush            = fl;
    bus_if.in_data   = x;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    if (fl) clearModel();
    exp_y = refModel(x, ca, cb, cc, cd);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = W'($urandom);
    flush           = chg;
    if (chg) begin
      a = ca ^ 8'hA5;
      b = W'($urandom);
      c = W'($urandom);
      d = W'($urandom);
    end
    checkOutput("busy_in_ready", 32'(bus_if.in_ready), 0);
    lat = 0;
    while (!bus_if.out_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 4);
    checkOutput("y", 32'(bus_if.out_data), 32'(exp_y));
    y = bus_if.out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 32'(bus_if.out_valid), 1);
      checkOutput("bp_data", 32'(bus_if.out_data), 32'(exp_y));
      checkOutput("bp_in_ready", 32'(bus_if.in_ready), 0);
    end
    @(negedge clk);
    flush            = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    checkOutput("hs_out_valid", 32'(bus_if.out_valid), 0);
    checkOutput("hs_in_ready", 32'(bus_if.in_ready), 1);
    mx1 = x;
    my2 = my1;
    my1 = exp_y;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] fib [14];
    fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    rst_n            = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    flush            = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    clearModel();
    #2;
    doReset();

    $display("[TB] pass-through");
    applyStimulus(8'd5, 8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, got);
    checkOutput("t1_y", 32'(got), 5);

    $display("[TB] truncation and x history");
    doReset();
    applyStimulus(8'd20, 8'd20, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, got);
    checkOutput("t3_y0", 32'(got), 144);
    applyStimulus(8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 1'b0, 0, 1'b0, got);
    checkOutput("t3_y1", 32'(got), 20);

    $display("[TB] fibonacci impulse response");
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i == 0) ? 8'd1 : 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b0, got);
      checkOutput("t2_fib", 32'(got), 32'(fib[i]));
    end

    $display("[TB] backpressure");
    applyStimulus(8'd3, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 10, 1'b0, got);
    applyStimulus(8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b0, got);

    $display("[TB] flush and coefficient change");
    applyFlush();
    applyStimulus(8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b0, got);
    checkOutput("t6_flush_y", 32'(got), 1);
    applyStimulus(8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b1, got);
    checkOutput("t6_latched_y", 32'(got), 1);

    $display("[TB] reset mid-MAC");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 0) ? 8'd1 : 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b0, got);
      checkOutput("t5_fib", 32'(got), 32'(fib[i]));
    end
    @(negedge clk);
    bus_if.in_data  = 8'd0;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_out_valid", 32'(bus_if.out_valid), 0);
    checkOutput("t5_out_data", 32'(bus_if.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    #1;
    checkOutput("t5_in_ready", 32'(bus_if.in_ready), 1);
    applyStimulus(8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 1'b0, 0, 1'b0, got);
    checkOutput("t5_y", 32'(got), 1);

    $display("[TB] randomized samples");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 3), ($urandom_range(0, 1) == 1), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
